// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start bit, DATA_W data bits LSB first,
// optional even-parity bit (SERIAL_FRAME_TX_PARITY_EN), stop bit; DIV clocks per bit.
module serial_frame_tx #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [DATA_W-1:0] DIN,
  input  logic              LOAD,
  output logic              READY,
  output logic              BUSY,
  output logic              TXD,
  output logic              TXD_n,
  output logic              DONE
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic               par_q, par_d;
`endif
  logic               txd_q, txd_d;
  logic               txd_n_q;
  logic               ready_q, ready_d;
  logic               busy_q;
  logic               done_q, done_d;
  logic               bit_end_s;

  assign bit_end_s = (cnt_q == LAST_CNT);

  // Next-state logic: advance one bit every DIV cycles while a frame is active
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_d   = par_q;
`endif
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (LOAD) begin
          state_d = S_START;
          shift_d = DIN;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
`endif
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so every port is a flop
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      S_STOP:   txd_d = 1'b1;
      default:  txd_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
      txd_q   <= 1'b1;
      txd_n_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
      txd_q   <= txd_d;
      txd_n_q <= ~txd_d;
      ready_q <= ready_d;
      busy_q  <= ~ready_d;
      done_q  <= done_d;
    end
  end

  assign TXD   = txd_q;
  assign TXD_n = txd_n_q;
  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed frame table plus random frames checked
// cycle by cycle against a bit-list model of the frame.
module tb_serial_frame_tx;

  localparam int DATA_W = 8;
  localparam int DIV    = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NB = DATA_W + 3;
`else
  localparam int NB = DATA_W + 2;
`endif
  localparam int F = NB * DIV;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic [DATA_W-1:0] DIN;
  logic              LOAD;
  logic              READY, BUSY, TXD, TXD_n, DONE;

  int vectors    = 0;
  int miscompares = 0;

  serial_frame_tx #(.DATA_W(DATA_W), .DIV(DIV)) dut (
    .CLK(CLK), .RST_n(RST_n), .DIN(DIN), .LOAD(LOAD),
    .READY(READY), .BUSY(BUSY), .TXD(TXD), .TXD_n(TXD_n), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       hold;     // keep LOAD=1, DIN=FF during the frame
    logic       b2b;      // next frame is loaded in this frame's DONE cycle
    logic       exp_par;  // even parity of data
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle;
    LOAD = 1'b0;
    tick();
    chk("idle_txd", TXD, 1'b1);
    chk("idle_txd_n", TXD_n, 1'b0);
    chk("idle_ready", READY, 1'b1);
    chk("idle_done", DONE, 1'b0);
  endtask

  // Called #1 after an edge with READY expected high; leaves us in the DONE cycle.
  task automatic run_frame(input logic [7:0] data, input logic hold, input logic exp_par);
    logic [NB-1:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) bits[1+i] = data[i];
`ifdef SERIAL_FRAME_TX_PARITY_EN
    bits[DATA_W+1] = exp_par;
`endif
    bits[NB-1] = 1'b1;
    chk("ready_before_load", READY, 1'b1);
    DIN  = data;
    LOAD = 1'b1;
    tick();
    for (int c = 0; c < F; c++) begin
      chk("txd", TXD, bits[c/DIV]);
      chk("txd_n", TXD_n, ~bits[c/DIV]);
      chk("ready_busy", READY, 1'b0);
      chk("busy", BUSY, 1'b1);
      chk("done_early", DONE, 1'b0);
      if (hold) begin
        LOAD = 1'b1;
        DIN  = 8'hFF;
      end else begin
        LOAD = 1'b0;
      end
      tick();
    end
    chk("end_txd", TXD, 1'b1);
    chk("end_txd_n", TXD_n, 1'b0);
    chk("end_ready", READY, 1'b1);
    chk("end_busy", BUSY, 1'b0);
    chk("end_done", DONE, 1'b1);
    LOAD = 1'b0;
  endtask

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{data: 8'hA5, hold: 1'b0, b2b: 1'b0, exp_par: 1'b0};
    tbl[1] = '{data: 8'hA5, hold: 1'b1, b2b: 1'b0, exp_par: 1'b0};
    tbl[2] = '{data: 8'h00, hold: 1'b0, b2b: 1'b1, exp_par: 1'b0};
    tbl[3] = '{data: 8'hFF, hold: 1'b0, b2b: 1'b0, exp_par: 1'b0};
    tbl[4] = '{data: 8'h07, hold: 1'b0, b2b: 1'b0, exp_par: 1'b1};
    tbl[5] = '{data: 8'h03, hold: 1'b0, b2b: 1'b1, exp_par: 1'b0};
    tbl[6] = '{data: 8'h01, hold: 1'b1, b2b: 1'b0, exp_par: 1'b1};

    RST_n = 1'b0;
    LOAD  = 1'b0;
    DIN   = 8'h00;
    tick();
    tick();
    chk("rst_txd", TXD, 1'b1);
    chk("rst_txd_n", TXD_n, 1'b0);
    chk("rst_ready", READY, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    RST_n = 1'b1;
    idle_cycle();

    // Directed frames
    for (int v = 0; v < 7; v++) begin
      run_frame(tbl[v].data, tbl[v].hold, tbl[v].exp_par);
      if (!tbl[v].b2b) idle_cycle();
    end

    // Randomised frames with random gaps (zero gap means back-to-back)
    for (int r = 0; r < 10; r++) begin
      logic [7:0] d;
      int gap;
      d   = 8'($urandom);
      gap = $urandom_range(0, 2);
      run_frame(d, 1'($urandom), ^d);
      for (int g = 0; g < gap; g++) idle_cycle();
    end
    idle_cycle();

    // Asynchronous reset during data bit 4 (frame bit 5)
    DIN  = 8'hA5;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    repeat (5*DIV + 2) tick();
    chk("mid_txd_bit4", TXD, 1'b0);
    chk("mid_busy", BUSY, 1'b1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("arst_txd", TXD, 1'b1);
    chk("arst_txd_n", TXD_n, 1'b0);
    chk("arst_ready", READY, 1'b1);
    chk("arst_busy", BUSY, 1'b0);
    chk("arst_done", DONE, 1'b0);
    tick();
    RST_n = 1'b1;
    for (int c = 0; c < F + 10; c++) idle_cycle();

    // A clean frame still works after the abort
    run_frame(8'h5A, 1'b0, 1'b0);
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
